// File: rtl/wb_stage_pipe_pkg.sv
// Shared definitions for the registered write-back stage: load encodings,
// FSM state names and byte-offset width helpers.
package wb_pkg;

  localparam int DATA_W_DFLT = 32;
  localparam int OFF_W       = $clog2(DATA_W_DFLT / 8);

  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_D  = 3'b011;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;
  localparam logic [2:0] LD_WU = 3'b110;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;

  function automatic int off_width(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/wb_stage_pipe_if.sv
// MEM/WB handshake, data-memory response and register-file write port bundle.
interface wb_stage_pipe_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              valid_in;
  logic              ready_out;
  logic              WB_en_in;
  logic              MEM_R_EN;
  logic [2:0]        ld_type;
  logic [DATA_W-1:0] ALU_result;
  logic [REG_AW-1:0] Dest_in;
  logic              flush;
  logic              mem_rvalid;
  logic [DATA_W-1:0] MEM_read_value;
  logic              WB_en;
  logic [DATA_W-1:0] Write_value;
  logic [REG_AW-1:0] Dest;
  logic              mem_tmo_err;

  modport slave (
    input  valid_in, WB_en_in, MEM_R_EN, ld_type, ALU_result, Dest_in,
           flush, mem_rvalid, MEM_read_value,
    output ready_out, WB_en, Write_value, Dest, mem_tmo_err
  );

  modport master (
    output valid_in, WB_en_in, MEM_R_EN, ld_type, ALU_result, Dest_in,
           flush, mem_rvalid, MEM_read_value,
    input  ready_out, WB_en, Write_value, Dest, mem_tmo_err
  );
endinterface

// File: rtl/wb_stage_pipe_load_formatter.sv
// Combinational sub-word load extraction with sign/zero extension.
module load_formatter
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_LW = off_width(DATA_W)
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic [OFF_LW-1:0] i_off,
  input  logic [2:0]        i_ld_type,
  output logic [DATA_W-1:0] o_value
);

  localparam int NB = DATA_W / 8;

  logic [7:0]        w_bytes [NB];
  logic [OFF_LW-1:0] w_off_h;
  logic [OFF_LW-1:0] w_off_w;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_word;

  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign w_bytes[gi] = i_data[8*gi +: 8];
  end

  // Misaligned halves/words round down to their natural boundary.
  assign w_off_h = i_off & ~OFF_LW'(1);
  assign w_off_w = i_off & ~OFF_LW'(3);

  assign w_byte = w_bytes[i_off];
  assign w_half = {w_bytes[w_off_h + OFF_LW'(1)], w_bytes[w_off_h]};
  assign w_word = {w_bytes[w_off_w + OFF_LW'(3)], w_bytes[w_off_w + OFF_LW'(2)],
                   w_bytes[w_off_w + OFF_LW'(1)], w_bytes[w_off_w]};

  always_comb begin
    o_value = DATA_W'($signed(w_word));
    case (i_ld_type)
      LD_B:  o_value = DATA_W'($signed(w_byte));
      LD_BU: o_value = DATA_W'(w_byte);
      LD_H:  o_value = DATA_W'($signed(w_half));
      LD_HU: o_value = DATA_W'(w_half);
      LD_WU: if (DATA_W == 64) o_value = DATA_W'(w_word);
      LD_D:  if (DATA_W == 64) o_value = i_data;
      default: o_value = DATA_W'($signed(w_word));
    endcase
  end

endmodule

// File: rtl/wb_stage_pipe.sv
// Registered write-back stage: waits on variable-latency memory for loads,
// formats the result and drives the register-file write port.
module wb_stage_pipe
  import wb_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int MEM_TMO = 15
) (
  input  logic           clk,
  input  logic           rst,
  wb_stage_pipe_if.slave bus
);

  localparam int OFF_LW = off_width(DATA_W);
  localparam logic [0:0] S_IDLE = 1'(IDLE);
  localparam logic [0:0] S_WAIT = 1'(WAIT_MEM);

  logic [0:0]        r_state;
  logic [7:0]        r_cnt;
  logic [OFF_LW-1:0] r_off;
  logic [2:0]        r_ld;
  logic [REG_AW-1:0] r_ldest;
  logic              r_wb_en;
  logic [DATA_W-1:0] r_wval;
  logic [REG_AW-1:0] r_dest;
  logic              r_tmo;

  logic              w_ready;
  logic              w_accept;
  logic [DATA_W-1:0] w_fmt;

  assign w_ready  = (r_state == S_IDLE);
  assign w_accept = bus.valid_in & w_ready & ~bus.flush;

  assign bus.ready_out   = w_ready;
  assign bus.WB_en       = r_wb_en;
  assign bus.Write_value = r_wval;
  assign bus.Dest        = r_dest;
  assign bus.mem_tmo_err = r_tmo;

  load_formatter #(.DATA_W(DATA_W)) u_fmt (
    .i_data    (bus.MEM_read_value),
    .i_off     (r_off),
    .i_ld_type (r_ld),
    .o_value   (w_fmt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_off   <= '0;
      r_ld    <= '0;
      r_ldest <= '0;
      r_wb_en <= 1'b0;
      r_wval  <= '0;
      r_dest  <= '0;
      r_tmo   <= 1'b0;
    end else begin
      r_wb_en <= 1'b0;
      r_tmo   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (bus.MEM_R_EN) begin
              r_state <= S_WAIT;
              r_cnt   <= '0;
              r_off   <= bus.ALU_result[OFF_LW-1:0];
              r_ld    <= bus.ld_type;
              r_ldest <= bus.Dest_in;
            end else begin
              r_wb_en <= bus.WB_en_in & (bus.Dest_in != '0);
              r_wval  <= bus.ALU_result;
              r_dest  <= bus.Dest_in;
            end
          end
        end
        default: begin
          // Priority: flush beats a returning response, which beats the watchdog.
          if (bus.flush) begin
            r_state <= S_IDLE;
          end else if (bus.mem_rvalid) begin
            r_state <= S_IDLE;
            r_wb_en <= (r_ldest != '0);
            r_wval  <= w_fmt;
            r_dest  <= r_ldest;
          end else if (r_cnt == 8'(MEM_TMO)) begin
            r_state <= S_IDLE;
            r_tmo   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
      endcase
    end
  end

endmodule
